datapath_mc: RTL
================

// Module: datapath_mc
// PURPOSE
//  Parametrised multi-cycle successor to the single-cycle datapath top. Owns the register file,
//  integer ALU and a byte-addressable data memory, sequenced by an internal FSM.
//  Accepts one decoded instruction per valid/ready handshake from the control unit.
//  Supports sub-word loads and stores (B/H/W, and D when WIDTH=64) with sign or zero extension.
//  Reports completion with a one-cycle done pulse.
// PARAMETERS
//  WIDTH      32  datapath/register width; legal values 32 or 64
//  NUM_REGS   32  architectural registers; x0 reads 0, writes to it are ignored; power of 2, max 32
//  MEM_DEPTH  256 data memory depth in WIDTH-bit words; power of 2
// PORTS
//  clk           in   1      clock; all state updates on the rising edge
//  rst           in   1      asynchronous, active-high reset
//  instr_valid   in   1      instruction fields valid
//  instr_ready   out  1      datapath can accept; high only in IDLE
//  opcode        in   7      RV opcode: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE
//  Funct3        in   3      RV funct3
//  Funct7        in   7      RV funct7; bit 5 selects SUB/SRA
//  RS1, RS2, RD  in   5      register indices; bits above log2(NUM_REGS) are ignored
//  Imm           in   12     immediate, pre-assembled by decode; sign-extended internally
//  done          out  1      one-cycle pulse when the instruction retires
//  illegal       out  1      qualifies done: opcode/funct unsupported, nothing written
//  misalign_err  out  1      qualifies done: misaligned access, nothing written (see CONFIGURATION)
//  result        out  WIDTH  value written to RD (ALU result or extended load data); valid with done
//  mem_addr_out  out  WIDTH  effective address of last memory op (debug)
// BEHAVIOUR
//  - Reset values: instr_ready=0 while rst is high and 1 in IDLE after release.
//    done, illegal, misalign_err, result and mem_addr_out reset to 0.
//    All registers reset to 0. Memory array is not reset.
//  - FSM states: IDLE, EXEC, MEM, WB.
//    - IDLE: on instr_valid && instr_ready, latch opcode/Funct3/Funct7/RS1/RS2/RD/Imm, then go to EXEC.
//    - EXEC: read RS1/RS2 and compute the ALU result or effective address (RS1 + sext(Imm)).
//      LOAD/STORE go to MEM; every other opcode goes to WB.
//    - MEM: a STORE performs a byte-enabled write; a LOAD performs a synchronous read. Then go to WB.
//    - WB: write RD if applicable, pulse done, return to IDLE.
//  - Latency, counted from the accept edge:
//    - ALU op: done asserted 2 cycles later.
//    - LOAD/STORE: done asserted 3 cycles later.
//    - Throughput: one instruction per 3 (ALU) or 4 (memory) cycles. No back-to-back accept.
//  - ALU operations:
//    - ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA.
//    - The I-type forms use sext(Imm) as operand B. There is no SUBI; I-type Funct7[5] is ignored except for SRAI.
//    - Shift amount is operand B[log2(WIDTH)-1:0].
//    - Add/sub wrap modulo 2^WIDTH. No overflow flag.
//  - Memory ops (Funct3):
//    - LOAD: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. When WIDTH=64, also 011 LD and 110 LWU.
//    - STORE: 000 SB, 001 SH, 010 SW. When WIDTH=64, also 011 SD.
//    - Lane select comes from the low address bits. Untouched bytes are preserved on store.
//    - Word index = addr >> log2(WIDTH/8), taken modulo MEM_DEPTH (wraps silently).
//  - Register-file writes:
//    - Writes to x0 are dropped, but result still shows the computed value.
//    - Operand reads in EXEC see all prior retired writes, since instructions are strictly serialised.
//  - Unsupported opcode or Funct3: EXEC -> WB, then done=1 with illegal=1. No register or memory write; result=0.
//  - instr_valid while not IDLE: ignored, and the fields are not sampled.
//  - rst asserted mid-instruction: FSM returns to IDLE immediately. No pending RD or memory write commits.
// CONFIGURATION
//  ALIGN_CHECK_EN defined:
//   - A halfword access with addr[0]!=0 is misaligned; a word access with addr[1:0]!=0 is misaligned;
//     a doubleword access with addr[2:0]!=0 is misaligned.
//   - A misaligned access skips the memory and register write.
//   - It retires with done=1, misalign_err=1, result=0. Latency is unchanged.
//  ALIGN_CHECK_EN undefined:
//   - misalign_err is tied to 0.
//   - The low address bits below the access size are forced to 0 (access rounded down to alignment).
// TESTING
//  1. After reset: ADDI x1,x0,-5 (Imm=12'hFFB) -> done at +2 cycles; result=32'hFFFFFFFB; x1 reads back the same.
//  2. x1=32'h80000000: SRAI x2,x1,4 -> x2=32'hF8000000. SRLI x3,x1,4 -> x3=32'h08000000. SLTU x4,x0,x1 -> 1.
//  3. SW of 32'h11223344 to addr 8, then SB of 8'hAA to addr 9, then LW from 8 -> 32'h1122AA44.
//     LB from 9 -> 32'hFFFFFFAA. LBU from 9 -> 32'h000000AA. Each retires at +3 cycles.
//  4. ADD x0,x1,x1 -> x0 still reads 0. Opcode 1111111 -> done with illegal=1, and no register changes.
//  5. LW from addr 6 -> with ALIGN_CHECK_EN, misalign_err=1 and RD unchanged; without it, data is read from addr 4.
//  6. Assert rst during MEM of an SW -> memory word unchanged, instr_ready=1 after release.
//     Address MEM_DEPTH*4 aliases word 0.

Source files
------------

// File: rtl/datapath_mc.sv
// datapath_mc: multi-cycle datapath with register file, integer ALU and byte-addressable memory.
// Define ALIGN_CHECK_EN to trap misaligned accesses; otherwise accesses are rounded down.
module datapath_mc #(
    parameter int WIDTH     = 32,
    parameter int NUM_REGS  = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       Funct3,
    input  logic [6:0]       Funct7,
    input  logic [4:0]       RS1,
    input  logic [4:0]       RS2,
    input  logic [4:0]       RD,
    input  logic [11:0]      Imm,
    output logic             done,
    output logic             illegal,
    output logic             misalign_err,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] mem_addr_out
);
    localparam int BYTES = WIDTH / 8;
    localparam int OW    = $clog2(BYTES);
    localparam int SW    = $clog2(WIDTH);
    localparam int RW    = $clog2(NUM_REGS);
    localparam int IW    = $clog2(MEM_DEPTH);
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;

    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;
    state_t state, state_nx;

    logic [6:0]       op_q, f7_q;
    logic [2:0]       f3_q;
    logic [RW-1:0]    rs1_q, rs2_q, rd_q;
    logic [11:0]      imm_q;
    logic [WIDTH-1:0] rf [NUM_REGS];
    logic [WIDTH-1:0] mem [MEM_DEPTH];
    logic [WIDTH-1:0] alu_q, addr_q, sdata_q, rdata_q;
    logic             ill_q, mis_q;

    logic [WIDTH-1:0] a, b, simm, alu, ea, ea_al;
    logic [SW-1:0]    sh;
    logic [OW-1:0]    smask, off;
    logic             is_r, is_i, is_l, is_s, mem_op, legal, mis;

    assign is_r   = op_q == OP_R;
    assign is_i   = op_q == OP_I;
    assign is_l   = op_q == OP_L;
    assign is_s   = op_q == OP_S;
    assign mem_op = is_l || is_s;
    assign a      = rf[rs1_q];
    assign simm   = {{(WIDTH-12){imm_q[11]}}, imm_q};
    assign b      = is_r ? rf[rs2_q] : simm;
    assign sh     = b[SW-1:0];
    assign ea     = a + simm;
    assign off    = ea[OW-1:0];
    assign smask  = OW'((1 << f3_q[1:0]) - 1);

    always_comb begin
        legal = 1'b0;
        unique case (1'b1)
            is_r: legal = f7_q == 7'h00
                       || (f7_q == 7'h20 && (f3_q == 3'b000 || f3_q == 3'b101));
            is_i: legal = 1'b1;
            is_l: legal = f3_q inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}
                       || (WIDTH == 64 && f3_q inside {3'd3, 3'd6});
            is_s: legal = f3_q inside {3'd0, 3'd1, 3'd2}
                       || (WIDTH == 64 && f3_q == 3'd3);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        alu = a & b;
        unique case (f3_q)
            3'b000: alu = (is_r && f7_q[5]) ? a - b : a + b;
            3'b001: alu = a << sh;
            3'b010: alu = WIDTH'($signed(a) < $signed(b));
            3'b011: alu = WIDTH'(a < b);
            3'b100: alu = a ^ b;
            3'b101: if (f7_q[5]) alu = WIDTH'($signed(a) >>> sh);
                    else         alu = a >> sh;
            3'b110: alu = a | b;
            default: alu = a & b;
        endcase
    end

    always_comb begin
`ifdef ALIGN_CHECK_EN
        mis   = mem_op && legal && ((off & smask) != '0);
        ea_al = ea;
`else
        mis   = 1'b0;
        ea_al = {ea[WIDTH-1:OW], off & ~smask};
`endif
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (instr_valid) state_nx = EXEC;
            EXEC:    state_nx = (mem_op && legal) ? MEM : WB;
            MEM:     state_nx = WB;
            default: state_nx = IDLE;
        endcase
    end

    assign instr_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Lane extraction and extension of the word fetched in MEM
    logic [IW-1:0]    widx;
    logic [OW-1:0]    loff;
    logic [BYTES-1:0] be;
    logic [WIDTH-1:0] wdata, lane, ld_ext, wb_val;
    logic [63:0]      l64, x64;
    logic             sg, wr_en;

    assign widx  = IW'(addr_q >> OW);
    assign loff  = OW'(addr_q);
    assign be    = BYTES'((9'd1 << (4'd1 << f3_q[1:0])) - 9'd1) << loff;
    assign wdata = sdata_q << {loff, 3'b000};
    assign lane  = rdata_q >> {loff, 3'b000};

    always_comb begin
        l64 = 64'(lane);
        sg  = !f3_q[2];
        unique case (f3_q[1:0])
            2'b00:   x64 = {{56{sg & l64[7]}}, l64[7:0]};
            2'b01:   x64 = {{48{sg & l64[15]}}, l64[15:0]};
            2'b10:   x64 = {{32{sg & l64[31]}}, l64[31:0]};
            default: x64 = l64;
        endcase
        ld_ext = WIDTH'(x64);
    end

    assign wb_val = (ill_q || mis_q || is_s) ? '0 : (is_l ? ld_ext : alu_q);
    assign wr_en  = !ill_q && !mis_q && !is_s && (rd_q != '0);

    always_ff @(posedge clk) begin
        if (!rst && state == MEM) begin
            if (is_s && !ill_q && !mis_q)
                for (int i = 0; i < BYTES; i++)
                    if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
            rdata_q <= mem[widx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0; f3_q <= '0; f7_q <= '0; imm_q <= '0;
            rs1_q <= '0; rs2_q <= '0; rd_q <= '0;
            alu_q <= '0; addr_q <= '0; sdata_q <= '0;
            ill_q <= 1'b0; mis_q <= 1'b0;
            done <= 1'b0; illegal <= 1'b0; misalign_err <= 1'b0;
            result <= '0; mem_addr_out <= '0;
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else begin
            done         <= 1'b0;
            illegal      <= 1'b0;
            misalign_err <= 1'b0;
            unique case (state)
                IDLE: if (instr_valid) begin
                    op_q  <= opcode;      f3_q  <= Funct3;
                    f7_q  <= Funct7;      imm_q <= Imm;
                    rs1_q <= RS1[RW-1:0]; rs2_q <= RS2[RW-1:0];
                    rd_q  <= RD[RW-1:0];
                end
                EXEC: begin
                    alu_q   <= alu;
                    addr_q  <= ea_al;
                    sdata_q <= rf[rs2_q];
                    ill_q   <= !legal;
                    mis_q   <= mis;
                    if (mem_op && legal) mem_addr_out <= ea;
                end
                MEM: ;
                default: begin
                    done         <= 1'b1;
                    illegal      <= ill_q;
                    misalign_err <= mis_q;
                    result       <= wb_val;
                    if (wr_en) rf[rd_q] <= wb_val;
                end
            endcase
        end
    end
endmodule
